// File: rtl/bar_height_scheduler_if.sv
// rtl/bar_height_scheduler_if.sv - magnitude sample handshake bundle for the bar height scheduler
//
// Purpose:
//   Carries one spectrum magnitude sample per transfer from the spectrum
//   producer (master) into the scheduler's shadow buffer (slave).
// Signals:
//   s_valid  producer has a sample on s_idx/s_mag
//   s_ready  scheduler can accept a sample this cycle
//   s_idx    bar index of the sample (IDX_W bits)
//   s_mag    16-bit unsigned magnitude
interface bar_height_scheduler_if #(
  parameter int IDX_W = 4
);
  logic             s_valid;
  logic             s_ready;
  logic [IDX_W-1:0] s_idx;
  logic [15:0]      s_mag;

  modport master (
    output s_valid,
    output s_idx,
    output s_mag,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_idx,
    input  s_mag,
    output s_ready
  );
endinterface

// File: rtl/bar_height_scheduler.sv
// rtl/bar_height_scheduler.sv - per-frame bar height sequencer with attack/decay and optional peak hold
//
// Purpose:
//   Collects magnitude samples into a shadow buffer while idle. On each rising
//   edge of vs it walks every bar once (one bar per cycle), setting the display
//   height with instant attack and linear decay, so heights only move during
//   vertical sync. Optional peak markers are built when PEAK_HOLD_EN is defined;
//   otherwise peak_height is tied to zero and no peak state exists.
// Ports:
//   Clk, Reset     clock and synchronous active-high reset
//   vs             vertical sync level, rising edge starts a commit
//   s_if (slave)   sample handshake: s_valid/s_ready/s_idx/s_mag
//   bar_height     committed heights, 10 bits per bar
//   peak_height    peak-marker heights, 10 bits per bar
//   busy           high while the commit walk is running
//   commit_done    one-cycle pulse after the last bar is committed
//   frame_overrun  one-cycle pulse when vs rises while a commit is in flight
module bar_height_scheduler #(
  parameter int BAR_COUNT  = 16,
  parameter int MAG_SHIFT  = 6,
  parameter int MAX_HEIGHT = 400,
  parameter int DECAY      = 4,
  parameter int PEAK_HOLD  = 30
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        vs,
  bar_height_scheduler_if.slave       s_if,
  output logic [BAR_COUNT-1:0][9:0]   bar_height,
  output logic [BAR_COUNT-1:0][9:0]   peak_height,
  output logic                        busy,
  output logic                        commit_done,
  output logic                        frame_overrun
);

  localparam int               IDX_W       = $clog2(BAR_COUNT);
  localparam logic [IDX_W-1:0] LAST_PTR    = IDX_W'(BAR_COUNT - 1);
  // One extra bit so the range check is meaningful even for power-of-two counts.
  localparam logic [IDX_W:0]   BAR_COUNT_W = (IDX_W + 1)'(BAR_COUNT);
  localparam logic [15:0]      MAX16       = 16'(MAX_HEIGHT);
  localparam logic [9:0]       DECAY10     = 10'(DECAY);
  localparam logic [10:0]      DECAY11     = 11'(DECAY);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic                      vs_q, vs_d;
  logic [15:0]               shadow_q [BAR_COUNT];
  logic [15:0]               shadow_d [BAR_COUNT];
  logic [BAR_COUNT-1:0][9:0] bar_height_q, bar_height_d;
  logic                      s_ready_q, s_ready_d;
  logic                      busy_q, busy_d;
  logic                      commit_done_q, commit_done_d;
  logic                      frame_overrun_q, frame_overrun_d;

  logic        vs_edge;
  logic        idx_in_range;
  logic [15:0] mag_shifted;
  logic [15:0] tgt16;
  logic [9:0]  tgt;
  logic [9:0]  h_cur;
  logic [9:0]  h_new;

  assign vs_edge      = vs & ~vs_q;
  assign idx_in_range = ({1'b0, s_if.s_idx} < BAR_COUNT_W);

  // Target and attack/decay for the bar under the pointer. Clamping is done at
  // full width so large magnitudes cannot wrap into small heights.
  always_comb begin
    mag_shifted = shadow_q[ptr_q] >> MAG_SHIFT;
    tgt16       = (mag_shifted > MAX16) ? MAX16 : mag_shifted;
    tgt         = 10'(tgt16);
    h_cur       = bar_height_q[ptr_q];
    if (tgt >= h_cur) begin
      h_new = tgt;
    end else if ({1'b0, h_cur} > ({1'b0, tgt} + DECAY11)) begin
      h_new = h_cur - DECAY10;
    end else begin
      // Falling bar lands exactly on its target instead of undershooting.
      h_new = tgt;
    end
  end

`ifdef PEAK_HOLD_EN
  localparam int              HOLD_W    = $clog2(PEAK_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(PEAK_HOLD);

  logic [BAR_COUNT-1:0][9:0] peak_q, peak_d;
  logic [HOLD_W-1:0]         hold_q [BAR_COUNT];
  logic [HOLD_W-1:0]         hold_d [BAR_COUNT];
  logic [9:0]                pk_cur, pk_new;
  logic [HOLD_W-1:0]         hold_cur, hold_new;

  always_comb begin
    pk_cur   = peak_q[ptr_q];
    hold_cur = hold_q[ptr_q];
    if (h_new >= pk_cur) begin
      pk_new   = h_new;
      hold_new = HOLD_INIT;
    end else if (hold_cur != '0) begin
      pk_new   = pk_cur;
      hold_new = hold_cur - HOLD_W'(1);
    end else begin
      // pk_cur > h_new here, so pk_cur - 1 cannot underflow.
      pk_new   = ((pk_cur - 10'd1) > h_new) ? (pk_cur - 10'd1) : h_new;
      hold_new = '0;
    end
  end

  always_comb begin
    peak_d = peak_q;
    hold_d = hold_q;
    if (state_q == COMMIT) begin
      peak_d[ptr_q] = pk_new;
      hold_d[ptr_q] = hold_new;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      peak_q <= '0;
      hold_q <= '{default: '0};
    end else begin
      peak_q <= peak_d;
      hold_q <= hold_d;
    end
  end

  assign peak_height = peak_q;
`else
  assign peak_height = '0;
`endif

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    vs_d            = vs;
    shadow_d        = shadow_q;
    bar_height_d    = bar_height_q;
    frame_overrun_d = 1'b0;

    // Out-of-range indices complete the handshake but are discarded.
    if (s_if.s_valid && s_ready_q && idx_in_range) begin
      shadow_d[s_if.s_idx] = s_if.s_mag;
    end

    case (state_q)
      IDLE: begin
        if (vs_edge) begin
          state_d = COMMIT;
          ptr_d   = '0;
        end
      end
      COMMIT: begin
        bar_height_d[ptr_q] = h_new;
        frame_overrun_d     = vs_edge;
        if (ptr_q == LAST_PTR) begin
          state_d = DONE;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      DONE: begin
        frame_overrun_d = vs_edge;
        state_d         = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered alongside the state they describe.
    s_ready_d     = (state_d == IDLE);
    busy_d        = (state_d == COMMIT);
    commit_done_d = (state_d == DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q         <= IDLE;
      ptr_q           <= '0;
      vs_q            <= 1'b0;
      shadow_q        <= '{default: '0};
      bar_height_q    <= '0;
      s_ready_q       <= 1'b1;
      busy_q          <= 1'b0;
      commit_done_q   <= 1'b0;
      frame_overrun_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      vs_q            <= vs_d;
      shadow_q        <= shadow_d;
      bar_height_q    <= bar_height_d;
      s_ready_q       <= s_ready_d;
      busy_q          <= busy_d;
      commit_done_q   <= commit_done_d;
      frame_overrun_q <= frame_overrun_d;
    end
  end

  assign s_if.s_ready  = s_ready_q;
  assign bar_height    = bar_height_q;
  assign busy          = busy_q;
  assign commit_done   = commit_done_q;
  assign frame_overrun = frame_overrun_q;

endmodule
